// File: rtl/mips_pkg.sv
// Shared encodings for the MEM-stage load/store path: access sizes, the load
// writeback select code, the LSU state type and the data returned on a bus abort.
package mips_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication and misalignment for the
// incoming access, plus lane extraction and sign/zero extension of returned load data.
module lsu_align
  import mips_pkg::*;
(
  input  logic [1:0]  st_lane_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        misaligned_o,
  input  logic [1:0]  ld_lane_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] rdata_shift;
  logic [15:0] half_sel;

  always_comb begin
    st_be_o      = 4'b1111;
    st_wdata_o   = st_data_i;
    misaligned_o = |st_lane_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_be_o      = 4'b0001 << st_lane_i;
        st_wdata_o   = {4{st_data_i[7:0]}};
        misaligned_o = 1'b0;
      end
      SZ_HALF: begin
        st_be_o      = st_lane_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o   = {2{st_data_i[15:0]}};
        misaligned_o = st_lane_i[0];
      end
      default: ;
    endcase
  end

  // Lane select by shifting the addressed byte down to bit 0.
  assign rdata_shift = ld_rdata_i >> {ld_lane_i, 3'b000};
  assign half_sel    = ld_lane_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & rdata_shift[7]}}, rdata_shift[7:0]};
      SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: one bus transaction per load/store, IDLE->REQ->DONE, stalling IF..MEM
// until bus_ready; LSU_BUS_TIMEOUT_EN adds a REQ timeout that aborts with bus_err_m.
module mem_stage_lsu
  import mips_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       alu_out_m,
  input  logic [31:0]       write_data_m,
  input  logic              mem_write_m,
  input  logic [1:0]        mem_to_reg_m,
  input  logic [1:0]        mem_data_size_m,
  input  logic              load_unsigned_m,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata,
  output logic [31:0]       read_data_m,
  output logic              stall_m,
  output logic              addr_exc_m,
  output logic              bus_err_m
);

  lsu_state_e        state_q;
  logic              bus_req_q, bus_we_q, addr_exc_q, is_load_q, uns_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q, read_data_q;
  logic [1:0]        lane_q, size_q;

  logic        access, is_load, misaligned, start;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_data;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;
  assign bus_err_m = bus_err_q;
`else
  assign bus_err_m = 1'b0;
`endif

  // A store beats a simultaneous load request.
  assign is_load = ~mem_write_m & (mem_to_reg_m == MEM_TO_REG_MEM);
  assign access  = mem_write_m | (mem_to_reg_m == MEM_TO_REG_MEM);
  assign start   = (state_q == IDLE) & access & ~misaligned;
  assign stall_m = start | (state_q == REQ);

  lsu_align u_align (
    .st_lane_i    (alu_out_m[1:0]),
    .st_size_i    (mem_data_size_m),
    .st_data_i    (write_data_m),
    .st_be_o      (be_d),
    .st_wdata_o   (wdata_d),
    .misaligned_o (misaligned),
    .ld_lane_i    (lane_q),
    .ld_size_i    (size_q),
    .ld_unsigned_i(uns_q),
    .ld_rdata_i   (bus_rdata),
    .ld_data_o    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0;
      read_data_q <= 32'h0;
      addr_exc_q  <= 1'b0;
      is_load_q   <= 1'b0;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      size_q      <= SZ_WORD;
`ifdef LSU_BUS_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      addr_exc_q <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
      bus_err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (access && misaligned) begin
            addr_exc_q <= 1'b1;
          end else if (access) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write_m;
            bus_addr_q  <= {alu_out_m[ADDR_W-1:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            is_load_q   <= is_load;
            uns_q       <= load_unsigned_m;
            lane_q      <= alu_out_m[1:0];
            size_q      <= mem_data_size_m;
            state_q     <= REQ;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_req_q <= 1'b0;
            if (is_load_q) read_data_q <= ld_data;
            state_q   <= DONE;
          end
`ifdef LSU_BUS_TIMEOUT_EN
          // The limit-th unanswered REQ cycle aborts; a ready in that cycle still completes.
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_req_q   <= 1'b0;
            bus_err_q   <= 1'b1;
            read_data_q <= TIMEOUT_DATA;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign read_data_m = read_data_q;
  assign addr_exc_m  = addr_exc_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed steps plus random accesses against a byte-level
// model of lanes, replication and extension; the timeout step needs LSU_BUS_TIMEOUT_EN.
module tb_mem_stage_lsu;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_out_m = '0, write_data_m = '0, bus_rdata = '0;
  logic        mem_write_m = 1'b0, load_unsigned_m = 1'b0, bus_ready = 1'b0;
  logic [1:0]  mem_to_reg_m = 2'b00, mem_data_size_m = 2'b00;
  logic        bus_req, bus_we, stall_m, addr_exc_m, bus_err_m;
  logic [31:0] bus_addr, bus_wdata, read_data_m;
  logic [3:0]  bus_be;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rd = 32'h0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .alu_out_m(alu_out_m), .write_data_m(write_data_m),
    .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m),
    .mem_data_size_m(mem_data_size_m), .load_unsigned_m(load_unsigned_m),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .read_data_m(read_data_m), .stall_m(stall_m), .addr_exc_m(addr_exc_m),
    .bus_err_m(bus_err_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Little-endian load: pick nb bytes starting at off, then extend as an integer.
  function automatic logic [31:0] model_load(input logic [31:0] r, input int off, input int nb,
                                             input bit uns);
    longint v;
    v = longint'(r >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    mem_write_m = 1'b0; mem_to_reg_m = 2'b00;
  endtask

  task automatic run_access(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                            input logic we, input logic [1:0] m2r, input logic [1:0] sz,
                            input logic uns, input int waits, input logic [31:0] rdat,
                            input logic exp_to);
    int off, nb, stalls, reqs, exp_stalls;
    bit done;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    off = int'(addr[1:0]);
    nb  = size_bytes(sz);
    for (int i = 0; i < 4; i++) begin
      e_be[i] = (i >= off) && (i < off + nb);
      e_wd[i*8 +: 8] = wd[(i % nb)*8 +: 8];
    end
    if (!we && m2r == 2'b01) exp_rd = exp_to ? 32'hDEAD_BEEF : model_load(rdat, off, nb, uns);
    else if (exp_to) exp_rd = 32'hDEAD_BEEF;
    exp_stalls = exp_to ? TO + 1 : waits + 2;
    alu_out_m = addr; write_data_m = wd; mem_write_m = we; mem_to_reg_m = m2r;
    mem_data_size_m = sz; load_unsigned_m = uns;
    stalls = 0; reqs = 0; done = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (stall_m) stalls++;
      if (bus_req) begin
        chk({tag, ".addr"}, bus_addr, {addr[31:2], 2'b00});
        chk({tag, ".be"}, {28'h0, bus_be}, {28'h0, e_be});
        chk({tag, ".we"}, {31'h0, bus_we}, {31'h0, we});
        if (we) chk({tag, ".wdata"}, bus_wdata, e_wd);
        bus_ready = (reqs == waits);
        bus_rdata = rdat;
        reqs++;
      end else if (!stall_m) begin
        chk({tag, ".rdata"}, read_data_m, exp_rd);
        chk({tag, ".stalls"}, stalls, exp_stalls);
        chk({tag, ".reqs"}, reqs, exp_to ? TO : waits + 1);
        chk({tag, ".err"}, {31'h0, bus_err_m}, {31'h0, exp_to});
        done = 1;
      end
      @(posedge clk);
      #1;
      bus_ready = 1'b0;
    end
    if (!done) chk({tag, ".timeout"}, 32'h0, 32'h1);
  endtask

  task automatic run_misaligned(input string tag, input logic [31:0] addr, input logic we,
                                input logic [1:0] sz);
    int pulses;
    bit saw_req;
    alu_out_m = addr; mem_write_m = we; mem_to_reg_m = 2'b01; mem_data_size_m = sz;
    pulses = 0; saw_req = 0;
    @(negedge clk);
    chk({tag, ".stall"}, {31'h0, stall_m}, 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (addr_exc_m) pulses++;
      if (bus_req || stall_m) saw_req = 1;
    end
    chk({tag, ".exc_pulses"}, pulses, 1);
    chk({tag, ".no_req"}, {31'h0, saw_req}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a, d, r;
    logic [1:0]  sz, m2r;
    logic        we;
    int          nb;

    // Reset state
    #2;
    chk("rst.req", {31'h0, bus_req}, 32'h0);
    chk("rst.addr", bus_addr, 32'h0);
    chk("rst.be", {28'h0, bus_be}, 32'h0);
    chk("rst.wdata", bus_wdata, 32'h0);
    chk("rst.rdata", read_data_m, 32'h0);
    chk("rst.stall", {31'h0, stall_m}, 32'h0);
    chk("rst.exc", {31'h0, addr_exc_m}, 32'h0);
    chk("rst.err", {31'h0, bus_err_m}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_access("st_byte", 32'h103, 32'h0000_00A5, 1'b1, 2'b00, 2'b10, 1'b0, 0, 32'h0, 1'b0);
    run_access("ld_half_s", 32'h102, 32'h0, 1'b0, 2'b01, 2'b01, 1'b0, 3, 32'h8001_7FFF, 1'b0);
    run_access("ld_half_u", 32'h102, 32'h0, 1'b0, 2'b01, 2'b01, 1'b1, 3, 32'h8001_7FFF, 1'b0);
    run_misaligned("mis_word", 32'h206, 1'b0, 2'b00);
    run_access("b2b_ldb", 32'h10, 32'h0, 1'b0, 2'b01, 2'b10, 1'b0, 0, 32'h1234_5680, 1'b0);
    run_access("b2b_stw", 32'h14, 32'hCAFE_F00D, 1'b1, 2'b00, 2'b00, 1'b0, 1, 32'h0, 1'b0);
    run_access("both_set", 32'h20, 32'h0000_BEEF, 1'b1, 2'b01, 2'b01, 1'b0, 0, 32'hFFFF_FFFF, 1'b0);
    run_access("sz11_word", 32'h30, 32'h0, 1'b0, 2'b01, 2'b11, 1'b0, 2, 32'h8765_4321, 1'b0);
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("quiet.req", {31'h0, bus_req}, 32'h0);
      chk("quiet.stall", {31'h0, stall_m}, 32'h0);
    end
    mem_to_reg_m = 2'b10;
    @(negedge clk);
    chk("noload.stall", {31'h0, stall_m}, 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();

    for (int n = 0; n < 24; n++) begin
      sz  = 2'($urandom_range(0, 3));
      a   = 32'h1000 + $urandom_range(0, 255);
      d   = $urandom;
      r   = $urandom;
      we  = 1'($urandom_range(0, 1));
      m2r = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
      nb  = size_bytes(sz);
      if (!(we || m2r == 2'b01)) continue;
      if ((int'(a[1:0]) % nb) != 0) run_misaligned("rnd_mis", a, we, sz);
      else run_access("rnd", a, d, we, m2r, sz, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), r, 1'b0);
    end

`ifdef LSU_BUS_TIMEOUT_EN
    run_access("timeout", 32'h40, 32'h0, 1'b0, 2'b01, 2'b00, 1'b0, 100000, 32'h0, 1'b1);
`endif

    // Reset asserted in REQ with bus_ready pending
    alu_out_m = 32'h80; mem_write_m = 1'b1; mem_to_reg_m = 2'b00; mem_data_size_m = 2'b00;
    write_data_m = 32'h5555_AAAA;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid.req_before", {31'h0, bus_req}, 32'h1);
    bus_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("mid.req", {31'h0, bus_req}, 32'h0);
    chk("mid.we", {31'h0, bus_we}, 32'h0);
    chk("mid.addr", bus_addr, 32'h0);
    chk("mid.be", {28'h0, bus_be}, 32'h0);
    chk("mid.wdata", bus_wdata, 32'h0);
    chk("mid.rdata", read_data_m, 32'h0);
    chk("mid.stall", {31'h0, stall_m}, 32'h0);
    exp_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("post.req", {31'h0, bus_req}, 32'h0);
    chk("post.stall", {31'h0, stall_m}, 32'h0);
    chk("post.rdata", read_data_m, exp_rd);
    chk("post.addr", bus_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit: consumes the EX/MEM pipeline register outputs (address, store data, size, load/store controls) and runs one transaction per instruction on the data-memory bus.
- Handles byte lanes, byte enables, sign/zero extension, misalignment detection and wait states.
- Stalls the pipeline until the bus completes.
- Sits between the EX/MEM register and the MEM/WB register; read_data_m feeds the MEM/WB register.

Parameters:
- ADDR_W, 32, bus address width.
- TIMEOUT_CYCLES, 255, maximum REQ cycles before abort; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alu_out_m  in  32  effective byte address
- write_data_m  in  32  store data, right-justified
- mem_write_m  in  1  store instruction
- mem_to_reg_m  in  2  2'b01 = load from memory; other codes = no load
- mem_data_size_m  in  2  00 word, 01 half, 10 byte, 11 treated as word
- load_unsigned_m  in  1  zero-extend sub-word loads
- bus_req  out  1  transaction request
- bus_we  out  1  write strobe
- bus_addr  out  ADDR_W  word-aligned address, bits[1:0]=0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ready  in  1  transaction complete this cycle
- bus_rdata  in  32  read data, valid when bus_ready
- read_data_m  out  32  aligned, extended load result
- stall_m  out  1  freeze IF..MEM stages
- addr_exc_m  out  1  misaligned access, one-cycle pulse
- bus_err_m  out  1  timeout pulse; optional feature only, tied 0 otherwise

Behaviour:
- access = mem_write_m | (mem_to_reg_m==2'b01). If both are set, the store wins.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, REQ, DONE.
- IDLE, access and aligned:
  - Register bus_addr={addr[31:2],2'b00}, bus_be, bus_wdata, bus_we, and lane/size/unsigned for the load.
  - Go to REQ. stall_m=1 combinationally this cycle.
- IDLE, access and misaligned:
  - No bus activity, no stall.
  - addr_exc_m=1 registered, asserted the next cycle for exactly one cycle.
  - Stay in IDLE.
- REQ:
  - bus_req=1, stall_m=1, and bus_addr/bus_be/bus_wdata/bus_we held stable.
  - On bus_ready: capture the formatted bus_rdata into read_data_m (loads only; stores leave it unchanged), drop bus_req next cycle, go to DONE.
- DONE:
  - stall_m=0 and bus_req=0. The instruction advances at this edge.
  - No new access is accepted in DONE; go to IDLE.
- Latency:
  - Zero-wait-state memory gives 2 stall cycles (IDLE, REQ) and read_data_m valid in DONE.
  - Each wait cycle adds one more stall cycle.
- Byte enables (little-endian):
  - Byte: be = 4'b0001<<addr[1:0].
  - Half: 0011 if addr[1]=0, else 1100.
  - Word: 1111.
- Store data: byte replicated to {4{b}}; half replicated to {2{h}}; word as-is.
- Load formatting:
  - Byte: select lane addr[1:0].
  - Half: select the lower or upper half by addr[1].
  - Sign-extend unless load_unsigned_m; word loads are passed through.
- Reset values:
  - bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, read_data_m=0, addr_exc_m=0, bus_err_m=0.
  - State=IDLE; stall_m=0 as a consequence.
- Reset mid-transaction: immediate return to IDLE with bus_req deasserted. A bus_ready arriving after reset is ignored.
- bus_ready outside REQ is ignored.

Optional Feature:
- Macro: LSU_BUS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on REQ entry and increments each REQ cycle without bus_ready.
  - When it reaches TIMEOUT_CYCLES: bus_req drops, bus_err_m pulses one cycle, read_data_m=32'hDEAD_BEEF, go to DONE.
  - bus_ready in the same cycle as the limit wins, giving a normal completion.
- Undefined: no counter is built, REQ waits indefinitely, and bus_err_m is tied 0.

Decomposition:
- Shared package mips_pkg holds:
  - Size encodings SZ_WORD/SZ_HALF/SZ_BYTE.
  - MEM_TO_REG_MEM=2'b01.
  - LSU state typedef {IDLE,REQ,DONE}.
  - TIMEOUT_DATA constant.
- One combinational sub-module, lsu_align, handles lane/byte-enable generation, store replication and load extraction/extension. The FSM stays in mem_stage_lsu.

Test Plan:
- Store byte, addr=0x103, data=0x000000A5, bus_ready one cycle after REQ:
  - bus_addr=0x100, be=1000, wdata=0xA5A5A5A5, bus_we=1.
  - stall_m high for 2 cycles.
- Load signed half, addr=0x102, bus_rdata=0x8001_7FFF, 3 wait cycles:
  - read_data_m=0xFFFF8001.
  - stall_m high for 5 cycles.
  - Repeat unsigned: read_data_m=0x00008001.
- Load word, addr=0x206:
  - addr_exc_m pulses once, bus_req never asserts, stall_m stays 0.
- Back-to-back load byte at 0x10 then store word at 0x14:
  - Two distinct REQ phases separated by DONE, with no re-trigger of the first access.
- rst_n asserted during REQ with bus_ready pending:
  - All outputs reach reset values asynchronously.
  - A later bus_ready causes no state change.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus_ready held 0:
  - bus_err_m pulses after 4 REQ cycles, read_data_m=0xDEADBEEF, stall releases the next cycle.
